// File: rtl/vec_seq_cpu.sv
// Multi-cycle vector processor core: vector register file, lane-serial ADD/MUL
// datapath, internal vector memory with a host fill port, and a two-state sequencer.
module vec_seq_cpu #(
  parameter  int ELEM_W    = 32,
  parameter  int NUM_ELEM  = 16,
  parameter  int LANES     = 4,
  parameter  int NUM_REGS  = 4,
  parameter  int MEM_DEPTH = 32,
  localparam int VW        = ELEM_W * NUM_ELEM,
  localparam int RW        = $clog2(NUM_REGS),
  localparam int AW        = $clog2(MEM_DEPTH),
  localparam int BEATS     = NUM_ELEM / LANES,
  localparam int INSTR_W   = 3 + 3 * RW + AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               done,
  output logic               err,
  output logic [VW-1:0]      out_data,
  output logic               out_valid,
  input  logic               host_we,
  input  logic [AW-1:0]      host_addr,
  input  logic [VW-1:0]      host_wdata,
  input  logic               err_clr
);

  localparam int SW = LANES * ELEM_W;
  localparam int PW = 2 * ELEM_W;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {S_IDLE, S_EXEC} state_e;
  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_STORE = 3'b010,
    OP_ADD   = 3'b011,
    OP_MUL   = 3'b100,
    OP_OUT   = 3'b101,
    OP_ILL6  = 3'b110,
    OP_ILL7  = 3'b111
  } op_e;

  state_e             r_state, w_next;
  logic [INSTR_W-1:0] r_instr;
  logic [BW-1:0]      r_beat;
  logic [VW-1:0]      r_regs [NUM_REGS];
  logic [VW-1:0]      r_mem  [MEM_DEPTH];
  logic               r_done, r_out_valid, r_err;
  logic [VW-1:0]      r_out_data;

  op_e           w_op;
  logic [RW-1:0] w_rd, w_rd_pair, w_rs1, w_rs2;
  logic [AW-1:0] w_addr;
  logic          w_multi, w_last, w_illegal;
  logic          w_ready, w_accept, w_exec, w_retire;

  assign w_op      = op_e'(r_instr[INSTR_W-1 -: 3]);
  assign w_rd      = r_instr[AW+3*RW-1 -: RW];
  assign w_rs1     = r_instr[AW+2*RW-1 -: RW];
  assign w_rs2     = r_instr[AW+RW-1 -: RW];
  assign w_addr    = r_instr[AW-1:0];
  assign w_rd_pair = w_rd ^ RW'(1);

  assign w_multi   = (w_op == OP_ADD) || (w_op == OP_MUL);
  assign w_illegal = (w_op == OP_ILL6) || (w_op == OP_ILL7);
  assign w_last    = !w_multi || (r_beat == BW'(BEATS - 1));

  // Sequencer: state register / next-state / outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (instr_valid) w_next = S_EXEC;
      S_EXEC:  if (w_last)      w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready  = (r_state == S_IDLE);
    w_exec   = (r_state == S_EXEC);
    w_accept = w_ready && instr_valid;
    w_retire = w_exec && w_last;
  end

  // One LANES-wide slice per beat; later beats never read slices already written,
  // so in-place aliasing of rd / rd^1 with the sources is safe.
  logic [SW-1:0] w_src_a, w_src_b, w_sum, w_lo, w_hi;
  logic [PW-1:0] w_prod;

  always_comb begin
    w_src_a = r_regs[w_rs1][r_beat*SW +: SW];
    w_src_b = r_regs[w_rs2][r_beat*SW +: SW];
    w_sum   = '0;
    w_lo    = '0;
    w_hi    = '0;
    w_prod  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_sum[l*ELEM_W +: ELEM_W] = w_src_a[l*ELEM_W +: ELEM_W] + w_src_b[l*ELEM_W +: ELEM_W];
      w_prod = PW'(w_src_a[l*ELEM_W +: ELEM_W]) * PW'(w_src_b[l*ELEM_W +: ELEM_W]);
      w_lo[l*ELEM_W +: ELEM_W] = w_prod[ELEM_W-1:0];
      w_hi[l*ELEM_W +: ELEM_W] = w_prod[PW-1:ELEM_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_exec) begin
      case (w_op)
        OP_LOAD: r_regs[w_rd] <= r_mem[w_addr];
        OP_ADD:  r_regs[w_rd][r_beat*SW +: SW] <= w_sum;
        OP_MUL: begin
          r_regs[w_rd][r_beat*SW +: SW]      <= w_lo;
          r_regs[w_rd_pair][r_beat*SW +: SW] <= w_hi;
        end
        default: ;
      endcase
    end
  end

  // Host write first so a coincident STORE to the same entry overrides it
  always_ff @(posedge clk) begin
    if (host_we) r_mem[host_addr] <= host_wdata;
    if (w_exec && (w_op == OP_STORE)) r_mem[w_addr] <= r_regs[w_rs1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr     <= '0;
      r_beat      <= '0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_done      <= w_retire;
      r_out_valid <= w_retire && (w_op == OP_OUT);
      if (w_accept) begin
        r_instr <= instr;
        r_beat  <= '0;
      end else if (w_exec) begin
        r_beat  <= r_beat + BW'(1);
      end
      if (w_retire && (w_op == OP_OUT)) r_out_data <= r_regs[w_rs1];
      if (w_retire && w_illegal) r_err <= 1'b1;
      else if (err_clr)          r_err <= 1'b0;
    end
  end

  assign instr_ready = w_ready;
  assign done        = r_done;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign err         = r_err;

endmodule

// File: tb/tb_vec_seq_cpu.sv
// Directed self-checking bench for vec_seq_cpu (default sizing: 16 x 32-bit
// elements, 4 lanes, 4 registers, 32-entry memory).
module tb_vec_seq_cpu;

  localparam int VW      = 512;
  localparam int AW      = 5;
  localparam int INSTR_W = 14;

  localparam logic [2:0] NOP = 3'b000, LOAD = 3'b001, STORE = 3'b010, ADD = 3'b011;
  localparam logic [2:0] MUL = 3'b100, OUT  = 3'b101, ILL6  = 3'b110, ILL7 = 3'b111;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [INSTR_W-1:0] instr = '0;
  logic               instr_valid = 1'b0;
  logic               instr_ready;
  logic               done;
  logic               err;
  logic [VW-1:0]      out_data;
  logic               out_valid;
  logic               host_we = 1'b0;
  logic [AW-1:0]      host_addr = '0;
  logic [VW-1:0]      host_wdata = '0;
  logic               err_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  int            lat;
  logic          busy, ov, da, e, ds;
  logic [VW-1:0] od;
  logic [VW-1:0] ramp, exp_v;

  vec_seq_cpu #(
    .ELEM_W(32), .NUM_ELEM(16), .LANES(4), .NUM_REGS(4), .MEM_DEPTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .done(done), .err(err), .out_data(out_data),
    .out_valid(out_valid), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] splat(input logic [31:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  task automatic host_write(input logic [AW-1:0] a, input logic [VW-1:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(posedge clk); #1;
    host_we = 1'b0;
  endtask

  // Offers one instruction in IDLE; reports latency in edges after the handshake
  // (-1 on timeout), whether instr_ready stayed low while busy, outputs on the
  // done cycle, and whether done/out_valid were still high one cycle later.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [AW-1:0] a,
                       output int l, output logic b, output logic v,
                       output logic [VW-1:0] d, output logic after, output logic er);
    instr = {op, rd, rs1, rs2, a}; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    l = -1; b = 1'b1; v = 1'b0; d = '0; er = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (instr_ready) b = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        l = n; v = out_valid; d = out_data; er = err;
        if (!instr_ready) b = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    after = done | out_valid;
  endtask

  // Single-beat instruction with a host write landing on its execute edge
  task automatic issue_with_host(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                 input logic [AW-1:0] a, input logic [AW-1:0] ha,
                                 input logic [VW-1:0] hd, output logic dn);
    instr = {op, rd, rs1, 2'd0, a}; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    host_we = 1'b1; host_addr = ha; host_wdata = hd;
    @(posedge clk); #1;
    host_we = 1'b0;
    dn = done;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic seen;
    #1;
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", instr_ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    host_write(5'd0, splat(32'h5555_5555));
    issue(LOAD, 2'd0, 2'd0, 2'd0, 5'd0, lat, busy, ov, od, da, e);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rst_pre_load_lat: got %0d want 1", lat); end
    // abort an ADD after two beats
    instr = {ADD, 2'd0, 2'd0, 2'd0, 5'd0}; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", instr_ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", done); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_done: got %b want 0", seen); end
    issue(OUT, 2'd0, 2'd0, 2'd0, 5'd0, lat, busy, ov, od, da, e);
    n_cmp++; if (od !== '0) begin n_bad++; $display("FAIL midrst_r0: got %h want 0", od); end
  endtask

  task automatic test_load_out();
    for (int i = 0; i < 16; i++) ramp[i*32 +: 32] = 32'(i + 1);
    host_write(5'd3, ramp);
    host_write(5'd4, splat(32'hFFFF_FFFF));
    issue(LOAD, 2'd0, 2'd0, 2'd0, 5'd3, lat, busy, ov, od, da, e);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL load0_lat: got %0d want 1", lat); end
    issue(LOAD, 2'd1, 2'd0, 2'd0, 5'd4, lat, busy, ov, od, da, e);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL load1_lat: got %0d want 1", lat); end
    issue(OUT, 2'd0, 2'd0, 2'd0, 5'd0, lat, busy, ov, od, da, e);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL out_lat: got %0d want 1", lat); end
    n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL out_valid: got %b want 1", ov); end
    n_cmp++; if (od !== ramp) begin n_bad++; $display("FAIL out_r0: got %h want %h", od, ramp); end
    n_cmp++; if (da !== 1'b0) begin n_bad++; $display("FAIL out_pulse_width: got %b want 0", da); end
  endtask

  task automatic test_add();
    issue(ADD, 2'd2, 2'd0, 2'd1, 5'd0, lat, busy, ov, od, da, e);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL add_lat: got %0d want 4", lat); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL add_ready_low: got %b want 1", busy); end
    n_cmp++; if (da !== 1'b0) begin n_bad++; $display("FAIL add_done_width: got %b want 0", da); end
    for (int i = 0; i < 16; i++) exp_v[i*32 +: 32] = 32'(i);
    issue(OUT, 2'd0, 2'd2, 2'd0, 5'd0, lat, busy, ov, od, da, e);
    n_cmp++; if (od !== exp_v) begin n_bad++; $display("FAIL add_wrap: got %h want %h", od, exp_v); end
  endtask

  task automatic test_mul();
    issue(MUL, 2'd2, 2'd1, 2'd1, 5'd0, lat, busy, ov, od, da, e);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL mul_lat: got %0d want 4", lat); end
    issue(OUT, 2'd0, 2'd2, 2'd0, 5'd0, lat, busy, ov, od, da, e);
    n_cmp++; if (od !== splat(32'h0000_0001)) begin n_bad++; $display("FAIL mul_lo: got %h want %h", od, splat(32'h1)); end
    issue(OUT, 2'd0, 2'd3, 2'd0, 5'd0, lat, busy, ov, od, da, e);
    n_cmp++; if (od !== splat(32'hFFFF_FFFE)) begin n_bad++; $display("FAIL mul_hi: got %h want %h", od, splat(32'hFFFF_FFFE)); end
    issue(MUL, 2'd0, 2'd0, 2'd0, 5'd0, lat, busy, ov, od, da, e);
    for (int i = 0; i < 16; i++) exp_v[i*32 +: 32] = 32'((i + 1) * (i + 1));
    issue(OUT, 2'd0, 2'd0, 2'd0, 5'd0, lat, busy, ov, od, da, e);
    n_cmp++; if (od !== exp_v) begin n_bad++; $display("FAIL mul_alias_lo: got %h want %h", od, exp_v); end
    issue(OUT, 2'd0, 2'd1, 2'd0, 5'd0, lat, busy, ov, od, da, e);
    n_cmp++; if (od !== '0) begin n_bad++; $display("FAIL mul_alias_hi: got %h want 0", od); end
  endtask

  task automatic test_store_host();
    issue_with_host(STORE, 2'd0, 2'd2, 5'd7, 5'd7, splat(32'hAAAA_AAAA), ds);
    n_cmp++; if (ds !== 1'b1) begin n_bad++; $display("FAIL store_done: got %b want 1", ds); end
    issue(LOAD, 2'd3, 2'd0, 2'd0, 5'd7, lat, busy, ov, od, da, e);
    issue(OUT, 2'd0, 2'd3, 2'd0, 5'd0, lat, busy, ov, od, da, e);
    n_cmp++; if (od !== splat(32'h1)) begin n_bad++; $display("FAIL store_wins: got %h want %h", od, splat(32'h1)); end
    host_write(5'd8, splat(32'h1234_5678));
    issue_with_host(LOAD, 2'd3, 2'd0, 5'd8, 5'd8, splat(32'h9ABC_DEF0), ds);
    issue(OUT, 2'd0, 2'd3, 2'd0, 5'd0, lat, busy, ov, od, da, e);
    n_cmp++; if (od !== splat(32'h1234_5678)) begin n_bad++; $display("FAIL load_old: got %h want %h", od, splat(32'h1234_5678)); end
    issue(LOAD, 2'd3, 2'd0, 2'd0, 5'd8, lat, busy, ov, od, da, e);
    issue(OUT, 2'd0, 2'd3, 2'd0, 5'd0, lat, busy, ov, od, da, e);
    n_cmp++; if (od !== splat(32'h9ABC_DEF0)) begin n_bad++; $display("FAIL load_new: got %h want %h", od, splat(32'h9ABC_DEF0)); end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 16; i++) exp_v[i*32 +: 32] = 32'((i + 1) * (i + 1));
    issue(ILL6, 2'd0, 2'd0, 2'd0, 5'd3, lat, busy, ov, od, da, e);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ill_lat: got %0d want 1", lat); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %b want 1", e); end
    issue(OUT, 2'd0, 2'd0, 2'd0, 5'd0, lat, busy, ov, od, da, e);
    n_cmp++; if (od !== exp_v) begin n_bad++; $display("FAIL ill_regs: got %h want %h", od, exp_v); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
    err_clr = 1'b1;
    issue(ILL7, 2'd0, 2'd0, 2'd0, 5'd0, lat, busy, ov, od, da, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_set_wins: got %b want 1", e); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clr: got %b want 0", err); end
    err_clr = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_stays_clr: got %b want 0", err); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    instr = {NOP, 2'd0, 2'd0, 2'd0, 5'd0}; instr_valid = 1'b1;
    @(posedge clk); #1;
    pat[0] = done;
    @(posedge clk); #1;
    pat[1] = done;
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", instr_ready); end
    @(posedge clk); #1;
    pat[2] = done;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    pat[3] = done;
    n_cmp++; if (pat !== 4'b1010) begin n_bad++; $display("FAIL b2b_done_pattern: got %b want 1010", pat); end
  endtask

  initial begin
    test_reset();
    test_load_out();
    test_add();
    test_mul();
    test_store_host();
    test_illegal();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
